// File: rtl/sap1_controller.sv
// Purpose : SAP-1 controller-sequencer; one-hot T1..T6 ring plus opcode decode into bus strobes.
// Latency : outputs are a combinational decode of the current state; one instruction takes 6 clocks (4/5/6 with VARIABLE_CYCLE=1).
// Backpr. : none; run is sampled only in IDLE, and HALT holds until reset_n.
//
// Ports:
//   clk, reset_n       : system clock, asynchronous active-low reset
//   run                : start enable, looked at only while IDLE
//   opcode[3:0]        : IR[7:4], used only in T4..T6
//   t_state[5:0]       : one-hot T-state (bit0=T1), zero in IDLE/HALT
//   pc_* / mar_load / ram_enable_output / ir_* / acc_* / b_load / alu_* / out_load : datapath strobes
//   halted             : high while in HALT
module sap1_controller #(
    parameter logic [3:0] OP_LDA         = 4'h0,
    parameter logic [3:0] OP_ADD         = 4'h1,
    parameter logic [3:0] OP_SUB         = 4'h2,
    parameter logic [3:0] OP_OUT         = 4'hE,
    parameter logic [3:0] OP_HLT         = 4'hF,
    parameter bit         VARIABLE_CYCLE = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       pc_enable_output,
    output logic       pc_increment,
    output logic       mar_load,
    output logic       ram_enable_output,
    output logic       ir_load,
    output logic       ir_enable_output,
    output logic       acc_load,
    output logic       acc_enable_output,
    output logic       b_load,
    output logic       alu_operation,
    output logic       alu_enable_output,
    output logic       out_load,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t r_state;
    state_t w_next;

    // Opcode classes; anything not recognised executes as a NOP.
    logic w_is_lda;
    logic w_is_add;
    logic w_is_sub;
    logic w_is_out;
    logic w_is_hlt;
    logic w_is_nop;

    assign w_is_lda = (opcode == OP_LDA);
    assign w_is_add = (opcode == OP_ADD);
    assign w_is_sub = (opcode == OP_SUB);
    assign w_is_out = (opcode == OP_OUT);
    assign w_is_hlt = (opcode == OP_HLT);
    assign w_is_nop = !(w_is_lda || w_is_add || w_is_sub || w_is_out || w_is_hlt);

    // Reset acts immediately, so every output (a pure decode of r_state)
    // drops to zero without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        t_state           = 6'b000000;
        pc_enable_output  = 1'b0;
        pc_increment      = 1'b0;
        mar_load          = 1'b0;
        ram_enable_output = 1'b0;
        ir_load           = 1'b0;
        ir_enable_output  = 1'b0;
        acc_load          = 1'b0;
        acc_enable_output = 1'b0;
        b_load            = 1'b0;
        alu_operation     = 1'b0;
        alu_enable_output = 1'b0;
        out_load          = 1'b0;
        halted            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_T1;
                end
            end

            // Fetch: opcode is deliberately not looked at in T1..T3.
            S_T1: begin
                t_state          = 6'b000001;
                pc_enable_output = 1'b1;
                mar_load         = 1'b1;
                w_next           = S_T2;
            end

            S_T2: begin
                t_state      = 6'b000010;
                pc_increment = 1'b1;
                w_next       = S_T3;
            end

            S_T3: begin
                t_state           = 6'b000100;
                ram_enable_output = 1'b1;
                ir_load           = 1'b1;
                w_next            = S_T4;
            end

            S_T4: begin
                t_state = 6'b001000;
                if (w_is_lda || w_is_add || w_is_sub) begin
                    ir_enable_output = 1'b1;
                    mar_load         = 1'b1;
                end else if (w_is_out) begin
                    acc_enable_output = 1'b1;
                    out_load          = 1'b1;
                end

                if (w_is_hlt) begin
                    w_next = S_HALT;
                end else if (VARIABLE_CYCLE && (w_is_out || w_is_nop)) begin
                    w_next = S_T1;
                end else begin
                    w_next = S_T5;
                end
            end

            S_T5: begin
                t_state = 6'b010000;
                if (w_is_lda) begin
                    ram_enable_output = 1'b1;
                    acc_load          = 1'b1;
                end else if (w_is_add || w_is_sub) begin
                    ram_enable_output = 1'b1;
                    b_load            = 1'b1;
                end

                if (VARIABLE_CYCLE && w_is_lda) begin
                    w_next = S_T1;
                end else begin
                    w_next = S_T6;
                end
            end

            S_T6: begin
                t_state = 6'b100000;
                if (w_is_add || w_is_sub) begin
                    alu_enable_output = 1'b1;
                    acc_load          = 1'b1;
                    alu_operation     = w_is_sub;
                end
                // run is not consulted here: a started machine keeps going.
                w_next = S_T1;
            end

            S_HALT: begin
                halted = 1'b1;
                w_next = S_HALT;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sap1_controller.sv
// Purpose : self-checking bench for sap1_controller, fixed-cycle (dut0) and variable-cycle (dut1) builds side by side.
// Latency : expected output words are queued as each edge is launched and popped one half-cycle later.
// Backpr. : none; every scenario runs a fixed number of cycles.
module tb_sap1_controller;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic [3:0] opcode;

    logic [5:0] t0, t1;
    logic ep0, cp0, lm0, ce0, li0, ei0, la0, ea0, lb0, su0, eu0, lo0, h0;
    logic ep1, cp1, lm1, ce1, li1, ei1, la1, ea1, lb1, su1, eu1, lo1, h1;

    sap1_controller #(.VARIABLE_CYCLE(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .t_state(t0),
        .pc_enable_output(ep0), .pc_increment(cp0), .mar_load(lm0),
        .ram_enable_output(ce0), .ir_load(li0), .ir_enable_output(ei0),
        .acc_load(la0), .acc_enable_output(ea0), .b_load(lb0),
        .alu_operation(su0), .alu_enable_output(eu0), .out_load(lo0), .halted(h0)
    );

    sap1_controller #(.VARIABLE_CYCLE(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .t_state(t1),
        .pc_enable_output(ep1), .pc_increment(cp1), .mar_load(lm1),
        .ram_enable_output(ce1), .ir_load(li1), .ir_enable_output(ei1),
        .acc_load(la1), .acc_enable_output(ea1), .b_load(lb1),
        .alu_operation(su1), .alu_enable_output(eu1), .out_load(lo1), .halted(h1)
    );

    // Observed word: {halted, t_state[5:0], Ep,Cp,Lm,CE,Li,Ei,La,Ea,Lb,Su,Eu,Lo}
    logic [18:0] obs0, obs1;
    assign obs0 = {h0, t0, ep0, cp0, lm0, ce0, li0, ei0, la0, ea0, lb0, su0, eu0, lo0};
    assign obs1 = {h1, t1, ep1, cp1, lm1, ce1, li1, ei1, la1, ea1, lb1, su1, eu1, lo1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          m0, m1;          // model state: 0=IDLE, 1..6=T1..T6, 7=HALT
    logic [18:0] q0[$];
    logic [18:0] q1[$];
    logic [18:0] e0, e1;

    // Control word table from the instruction set description.
    function automatic logic [18:0] model_out(int s, logic [3:0] op);
        logic [11:0] c;
        logic [5:0]  t;
        c = 12'h000;
        t = 6'h00;
        if (s >= 1 && s <= 6) t = 6'h01 << (s - 1);
        case (s)
            1: c = 12'hA00;                                   // Ep Lm
            2: c = 12'h400;                                   // Cp
            3: c = 12'h180;                                   // CE Li
            4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) c = 12'h240;  // Ei Lm
               else if (op == 4'hE) c = 12'h011;              // Ea Lo
            5: if (op == 4'h0) c = 12'h120;                   // CE La
               else if (op == 4'h1 || op == 4'h2) c = 12'h108; // CE Lb
            6: if (op == 4'h1) c = 12'h022;                   // Eu La
               else if (op == 4'h2) c = 12'h026;              // Eu La Su
            default: c = 12'h000;
        endcase
        return {(s == 7), t, c};
    endfunction

    function automatic int model_next(int s, logic [3:0] op, logic r, bit vc);
        bit known;
        known = (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'hE) || (op == 4'hF);
        case (s)
            0: return r ? 1 : 0;
            1: return 2;
            2: return 3;
            3: return 4;
            4: begin
                if (op == 4'hF) return 7;
                if (vc && (op == 4'hE || !known)) return 1;
                return 5;
            end
            5: return (vc && op == 4'h0) ? 1 : 6;
            6: return 1;
            default: return 7;
        endcase
    endfunction

    // Launch one clock edge: queue what each build must show afterwards.
    task automatic advance();
        m0 = model_next(m0, opcode, run, 1'b0);
        m1 = model_next(m1, opcode, run, 1'b1);
        @(negedge clk);
        q0.push_back(model_out(m0, opcode));
        q1.push_back(model_out(m1, opcode));
    endtask

    task automatic apply_reset();
        run = 1'b0;
        #1 reset_n = 1'b0;
        m0 = 0;
        m1 = 0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        run     = 1'b1;
        opcode  = 4'h1;
        @(negedge clk);
        checks += 2;
        if (obs0 !== 19'h0) $display("FAIL reset_in dut0: got %05h want %05h", obs0, 19'h0); else passed++;
        if (obs1 !== 19'h0) $display("FAIL reset_in dut1: got %05h want %05h", obs1, 19'h0); else passed++;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            advance();
            e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
            if (obs0 !== e0) $display("FAIL idle dut0 cyc %0d: got %05h want %05h", i, obs0, e0); else passed++;
            if (obs1 !== e1) $display("FAIL idle dut1 cyc %0d: got %05h want %05h", i, obs1, e1); else passed++;
        end
    endtask

    // ADD/SUB: opcode scrambled during fetch, run dropped after start.
    task automatic test_alu(input logic [3:0] op);
        apply_reset();
        opcode = op;
        run    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            advance();
            e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
            if (obs0 !== e0) $display("FAIL alu%0h dut0 cyc %0d: got %05h want %05h", op, i, obs0, e0); else passed++;
            if (obs1 !== e1) $display("FAIL alu%0h dut1 cyc %0d: got %05h want %05h", op, i, obs1, e1); else passed++;
            run    = 1'b0;
            opcode = (i < 2) ? 4'($urandom_range(0, 15)) : op;
        end
    endtask

    task automatic test_out();
        apply_reset();
        opcode = 4'hE;
        run    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            advance();
            e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
            if (obs0 !== e0) $display("FAIL out dut0 cyc %0d: got %05h want %05h", i, obs0, e0); else passed++;
            if (obs1 !== e1) $display("FAIL out dut1 cyc %0d: got %05h want %05h", i, obs1, e1); else passed++;
        end
    endtask

    task automatic test_hlt();
        apply_reset();
        opcode = 4'hF;
        run    = 1'b1;
        for (int i = 0; i < 25; i++) begin
            advance();
            e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
            if (obs0 !== e0) $display("FAIL hlt dut0 cyc %0d: got %05h want %05h", i, obs0, e0); else passed++;
            if (obs1 !== e1) $display("FAIL hlt dut1 cyc %0d: got %05h want %05h", i, obs1, e1); else passed++;
            if (i >= 4) begin
                run    = ~run;
                opcode = 4'($urandom_range(0, 15));
            end
        end
        #1 reset_n = 1'b0;
        #1;
        checks += 2;
        if (obs0 !== 19'h0) $display("FAIL hlt_reset dut0: got %05h want %05h", obs0, 19'h0); else passed++;
        if (obs1 !== 19'h0) $display("FAIL hlt_reset dut1: got %05h want %05h", obs1, 19'h0); else passed++;
        apply_reset();
    endtask

    // Reset dropped between edges while LDA sits in T5.
    task automatic test_async_reset();
        apply_reset();
        opcode = 4'h0;
        run    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            advance();
            e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
            if (obs0 !== e0) $display("FAIL lda dut0 cyc %0d: got %05h want %05h", i, obs0, e0); else passed++;
            if (obs1 !== e1) $display("FAIL lda dut1 cyc %0d: got %05h want %05h", i, obs1, e1); else passed++;
        end
        #1 reset_n = 1'b0;
        run = 1'b0;
        #1;
        checks += 2;
        if (obs0 !== 19'h0) $display("FAIL async_rst dut0: got %05h want %05h", obs0, 19'h0); else passed++;
        if (obs1 !== 19'h0) $display("FAIL async_rst dut1: got %05h want %05h", obs1, 19'h0); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        m0 = 0;
        m1 = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) run = 1'b1;
            advance();
            e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
            if (obs0 !== e0) $display("FAIL restart dut0 cyc %0d: got %05h want %05h", i, obs0, e0); else passed++;
            if (obs1 !== e1) $display("FAIL restart dut1 cyc %0d: got %05h want %05h", i, obs1, e1); else passed++;
        end
    endtask

    task automatic test_all_opcodes();
        int n0, n1;
        for (int op = 0; op < 16; op++) begin
            apply_reset();
            opcode = 4'(op);
            run    = 1'b1;
            for (int i = 0; i < 8; i++) begin
                advance();
                e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 4;
                n0 = $countones({ep0, ce0, ei0, ea0, eu0});
                n1 = $countones({ep1, ce1, ei1, ea1, eu1});
                if (obs0 !== e0) $display("FAIL op%0h dut0 cyc %0d: got %05h want %05h", op, i, obs0, e0); else passed++;
                if (obs1 !== e1) $display("FAIL op%0h dut1 cyc %0d: got %05h want %05h", op, i, obs1, e1); else passed++;
                if (n0 > 1) $display("FAIL bus op%0h dut0 cyc %0d: drivers %0d want <=1", op, i, n0); else passed++;
                if (n1 > 1) $display("FAIL bus op%0h dut1 cyc %0d: drivers %0d want <=1", op, i, n1); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        opcode = 4'h0;
        run    = 1'b1;
        for (int i = 0; i < 14; i++) begin
            advance();
            e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
            if (obs0 !== e0) $display("FAIL b2b dut0 cyc %0d: got %05h want %05h", i, obs0, e0); else passed++;
            if (obs1 !== e1) $display("FAIL b2b dut1 cyc %0d: got %05h want %05h", i, obs1, e1); else passed++;
            run = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        opcode  = 4'h0;
        m0      = 0;
        m1      = 0;
        test_reset();
        test_alu(4'h1);
        test_alu(4'h2);
        test_out();
        test_hlt();
        test_async_reset();
        test_all_opcodes();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
